// File: rtl/recorder_iq_packer.sv
// recorder_iq_packer
//   Packs baseband IQ samples into 64-bit little-endian words for the
//   recorder write path (feeds the sample FIFO / AXI writer).
//   Formats: 16-, 12- or 8-bit components. Each sample field is {im,re}
//   with re in the LSBs. Fields are streamed into an 88-bit accumulator
//   and a word is emitted whenever 64 bits are available.
//
//   Optional build macro: IQ_PACKER_ROUND_EN
//     undefined : modes 1/2 truncate; word appears one cycle after the
//                 completing strobe.
//     defined   : modes 1/2 round half-up with saturation; one extra
//                 register stage on the reduction path (2-cycle latency).
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   enable           packing active; rising edge starts a recording
//   mode[1:0]        0=16b, 1=12b, 2=8b, 3=as 0 (latched on enable rise)
//   re_in, im_in     16-bit two's complement components
//   strobe_in        re_in/im_in valid this cycle
//   out_data[63:0]   packed word, held while out_valid && !out_ready
//   out_valid        out_data valid
//   out_ready        downstream accept
//   dropped_samples  sticky: a completed word was discarded
//   word_count[31:0] words loaded since last enable rise (wraps)

module recorder_iq_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] re_in,
    input  logic [15:0] im_in,
    input  logic        strobe_in,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        dropped_samples,
    output logic [31:0] word_count
);

    logic        enable_q;
    logic [1:0]  mode_q;
    logic        rise;
    logic [1:0]  eff_mode;
    logic [11:0] re12, im12;
    logic [7:0]  re8, im8;
    logic [31:0] field;
    logic [6:0]  width;

    logic [87:0] acc;
    logic [6:0]  fill;
    logic [87:0] base_acc, sum_acc;
    logic [6:0]  base_fill, sum_fill;
    logic        complete;

    // Signals seen by the accumulator stage
    logic        pk_en, pk_rise, pk_vld;
    logic [31:0] pk_field;
    logic [6:0]  pk_width;

    assign rise = enable && !enable_q;
    // On the rise cycle mode_q is not yet loaded, so use the live mode.
    assign eff_mode = rise ? mode : mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= 1'b0;
            mode_q   <= 2'd0;
        end else begin
            enable_q <= enable;
            if (rise)
                mode_q <= mode;
        end
    end

`ifdef IQ_PACKER_ROUND_EN
    // Round half-up, saturating at the positive rail (adding a positive
    // constant can only overflow upward).
    function automatic logic [11:0] rnd12(input logic [15:0] x);
        logic [16:0] s;
        s = {x[15], x} + 17'd8;
        rnd12 = (s[16] != s[15]) ? 12'h7FF : s[15:4];
    endfunction

    function automatic logic [7:0] rnd8(input logic [15:0] x);
        logic [16:0] s;
        s = {x[15], x} + 17'd128;
        rnd8 = (s[16] != s[15]) ? 8'h7F : s[15:8];
    endfunction

    assign re12 = rnd12(re_in);
    assign im12 = rnd12(im_in);
    assign re8  = rnd8(re_in);
    assign im8  = rnd8(im_in);
`else
    assign re12 = re_in[15:4];
    assign im12 = im_in[15:4];
    assign re8  = re_in[15:8];
    assign im8  = im_in[15:8];
`endif

    always_comb begin
        field = {im_in, re_in};
        width = 7'd32;
        case (eff_mode)
            2'd1: begin
                field = {8'd0, im12, re12};
                width = 7'd24;
            end
            2'd2: begin
                field = {16'd0, im8, re8};
                width = 7'd16;
            end
            default: ;
        endcase
    end

`ifdef IQ_PACKER_ROUND_EN
    // Extra stage: enable/rise travel with the field so the accumulator
    // sees a consistent, one-cycle-delayed view of the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pk_en    <= 1'b0;
            pk_rise  <= 1'b0;
            pk_vld   <= 1'b0;
            pk_field <= '0;
            pk_width <= '0;
        end else begin
            pk_en    <= enable;
            pk_rise  <= rise;
            pk_vld   <= strobe_in && enable;
            pk_field <= field;
            pk_width <= width;
        end
    end
`else
    assign pk_en    = enable;
    assign pk_rise  = rise;
    assign pk_vld   = strobe_in && enable;
    assign pk_field = field;
    assign pk_width = width;
`endif

    // Fill never exceeds 80 (worst case 56+24 in 12-bit mode), so the
    // 88-bit accumulator cannot overflow.
    always_comb begin
        base_acc  = pk_rise ? 88'd0 : acc;
        base_fill = pk_rise ? 7'd0  : fill;
        sum_acc   = base_acc | ({56'd0, pk_field} << base_fill);
        sum_fill  = base_fill + pk_width;
        complete  = pk_vld && (sum_fill >= 7'd64);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc             <= '0;
            fill            <= '0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            dropped_samples <= 1'b0;
            word_count      <= '0;
        end else begin
            if (!pk_en) begin
                // Partial word is discarded, never flushed.
                acc  <= '0;
                fill <= '0;
            end else if (pk_vld) begin
                if (complete) begin
                    acc  <= sum_acc >> 64;
                    fill <= sum_fill - 7'd64;
                end else begin
                    acc  <= sum_acc;
                    fill <= sum_fill;
                end
            end else if (pk_rise) begin
                acc  <= '0;
                fill <= '0;
            end

            if (pk_rise) begin
                dropped_samples <= 1'b0;
                word_count      <= '0;
            end

            // A word can complete on the same cycle the held word is
            // accepted; that is a load, not a drop.
            if (complete && (!out_valid || out_ready)) begin
                out_data   <= sum_acc[63:0];
                out_valid  <= 1'b1;
                word_count <= word_count + 32'd1;
            end else begin
                if (complete)
                    dropped_samples <= 1'b1;
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule
